// File: rtl/frame_source_if.sv
// Framed-data bus between the host/accumulator side and frame_source.
// master is the frame_source side; slave is the host/downstream side.
interface frame_source_if #(
  parameter int NOF_BITS = 32,
  parameter int DEPTH    = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                wr_en;
  logic [NOF_BITS-1:0] wr_data;
  logic                start;
  logic                sum_done;
  logic                data_first;
  logic                data_last;
  logic [NOF_BITS-1:0] data_out;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                busy;
  logic                ovf;
  logic                frame_sent;

  modport master (
    input  wr_en, wr_data, start, sum_done,
    output data_first, data_last, data_out, count, full, busy, ovf, frame_sent
  );

  modport slave (
    output wr_en, wr_data, start, sum_done,
    input  data_first, data_last, data_out, count, full, busy, ovf, frame_sent
  );
endinterface

// File: rtl/frame_source.sv
// Transmit end of the averager: buffers host words, replays them as one framed
// burst on start, then holds off until the accumulator acknowledges with sum_done.
module frame_source #(
  parameter int NOF_BITS = 32,
  parameter int DEPTH    = 16
) (
  input logic            clk,
  input logic            rst_n,
  frame_source_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [NOF_BITS-1:0] dout_q, dout_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic                ovf_q, ovf_d;
  logic                sent_q, sent_d;
  logic                full_q, full_d;
  logic                busy_q, busy_d;
  logic                we_s;
  logic [AW-1:0]       waddr_s;
  logic [AW-1:0]       raddr_s;
  logic [NOF_BITS-1:0] mem_q [DEPTH];

  assign waddr_s = count_q[AW-1:0];
  assign raddr_s = idx_q[AW-1:0];

  // Next-state and registered-output computation for the frame sequencer.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    idx_d   = idx_q;
    dout_d  = {NOF_BITS{1'b0}};
    first_d = 1'b0;
    last_d  = 1'b0;
    ovf_d   = 1'b0;
    sent_d  = 1'b0;
    we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wr_en) begin
          if (full_q) begin
            ovf_d = 1'b1;
          end else begin
            we_s    = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          we_s = 1'b0;
        end
        // Word 0 is driven at the start edge; bypass the write port when it lands now.
        if (bus.start && (count_d != {CNT_W{1'b0}})) begin
          state_d = SEND;
          len_d   = count_d;
          idx_d   = CNT_W'(1);
          dout_d  = (count_q == {CNT_W{1'b0}}) ? bus.wr_data : mem_q[{AW{1'b0}}];
          first_d = 1'b1;
          last_d  = (count_d == CNT_W'(1));
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (idx_q == len_q) begin
          state_d = WAIT_DONE;
        end else begin
          dout_d = mem_q[raddr_s];
          last_d = (idx_q == (len_q - CNT_W'(1)));
          idx_d  = idx_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.sum_done) begin
          count_d = {CNT_W{1'b0}};
          sent_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    full_d = (count_d == CNT_W'(DEPTH));
    busy_d = (state_d != IDLE);
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= {CNT_W{1'b0}};
      len_q   <= {CNT_W{1'b0}};
      idx_q   <= {CNT_W{1'b0}};
      dout_q  <= {NOF_BITS{1'b0}};
      first_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sent_q  <= 1'b0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      first_q <= first_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      sent_q  <= sent_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
    end
  end

  // Frame buffer; contents survive a frame, only the count is cleared.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[waddr_s] <= bus.wr_data;
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.data_first = first_q;
  assign bus.data_last  = last_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.busy       = busy_q;
  assign bus.ovf        = ovf_q;
  assign bus.frame_sent = sent_q;
endmodule

// File: tb/tb_frame_source.sv
// Randomized bench for frame_source: a queue-based frame model predicts every
// output each cycle, and a small accumulator pins frame sums to literal values.
module tb_frame_source;
  localparam int NB    = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  frame_source_if #(.NOF_BITS(NB), .DEPTH(DEPTH)) bus ();
  frame_source #(.NOF_BITS(NB), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: buffered words, words still to transmit, post-frame phases.
  logic [NB-1:0] m_buf[$];
  logic [NB-1:0] m_tx[$];
  bit            m_tail = 1'b0;
  bit            m_wait = 1'b0;
  logic [NB-1:0] e_dout = '0;
  bit e_first = 1'b0, e_last = 1'b0, e_ovf = 1'b0, e_sent = 1'b0, e_busy = 1'b0, e_full = 1'b0;
  int e_count = 0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc++;
    e_dout = '0; e_first = 1'b0; e_last = 1'b0; e_ovf = 1'b0; e_sent = 1'b0;
    if (!rst_n) begin
      m_buf.delete(); m_tx.delete(); m_tail = 1'b0; m_wait = 1'b0;
    end else if (m_tail) begin
      m_tail = 1'b0; m_wait = 1'b1;
    end else if (m_wait) begin
      if (bus.sum_done) begin
        m_wait = 1'b0; m_buf.delete(); e_sent = 1'b1;
      end
    end else if (m_tx.size() > 0) begin
      e_dout = m_tx.pop_front();
      e_last = (m_tx.size() == 0);
      m_tail = e_last;
    end else begin
      if (bus.wr_en) begin
        if (m_buf.size() == DEPTH) e_ovf = 1'b1;
        else m_buf.push_back(bus.wr_data);
      end
      if (bus.start && m_buf.size() > 0) begin
        m_tx    = m_buf;
        e_dout  = m_tx.pop_front();
        e_first = 1'b1;
        e_last  = (m_tx.size() == 0);
        m_tail  = e_last;
      end
    end
    e_busy  = m_tail || m_wait || (m_tx.size() > 0);
    e_count = m_buf.size();
    e_full  = (m_buf.size() == DEPTH);
  end

  // Compare process, downstream accumulator and sum_done generation.
  bit chk_en = 1'b0, auto_done = 1'b1, rnd_done = 1'b0;
  bit in_frame = 1'b0, pend = 1'b0;
  logic [32:0] acc = '0;
  logic [32:0] sums[$];
  logic [NB-1:0] words[$];
  int last_cyc = 0, ovf_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_out",   64'(bus.data_out),   64'(e_dout));
      chk("data_first", 64'(bus.data_first), 64'(e_first));
      chk("data_last",  64'(bus.data_last),  64'(e_last));
      chk("count",      64'(bus.count),      64'(e_count));
      chk("full",       64'(bus.full),       64'(e_full));
      chk("busy",       64'(bus.busy),       64'(e_busy));
      chk("ovf",        64'(bus.ovf),        64'(e_ovf));
      chk("frame_sent", 64'(bus.frame_sent), 64'(e_sent));
    end
    if (!rst_n) begin
      in_frame = 1'b0; pend = 1'b0; bus.sum_done = 1'b0;
    end else begin
      if (auto_done && bus.data_first) chk("first_vs_done", 64'(bus.sum_done), 64'd0);
      if (bus.data_first) begin in_frame = 1'b1; acc = '0; end
      if (in_frame) begin
        acc = acc + {1'b0, bus.data_out};
        words.push_back(bus.data_out);
      end
      if (bus.data_last) begin
        sums.push_back(acc); in_frame = 1'b0; last_cyc = cyc;
      end
      if (bus.ovf) ovf_cnt++;
      if (bus.frame_sent && auto_done) chk("sent_gap", 64'(cyc - last_cyc), 64'd2);
      if (auto_done) bus.sum_done = pend;
      else if (rnd_done) bus.sum_done = ($urandom_range(0, 3) == 0);
      else bus.sum_done = 1'b0;
      pend = bus.data_last;
    end
  end

  function automatic logic [63:0] sum_at(input int i);
    if (i < sums.size()) return 64'(sums[i]);
    else return 64'hDEAD_0000_0000_0000;
  endfunction

  function automatic logic [63:0] word_at(input int i);
    if (i >= 0 && i < words.size()) return 64'(words[i]);
    else return 64'hDEAD_0000_0000_0000;
  endfunction

  task automatic cyc_in(input bit we, input logic [NB-1:0] d, input bit st);
    bus.wr_en = we; bus.wr_data = d; bus.start = st;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (e_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n >= 300), 64'd0);
  endtask

  int ovf_base;

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_data_out", 64'(bus.data_out), 64'd0);
    chk("rst_count",    64'(bus.count),    64'd0);
    chk("rst_busy",     64'(bus.busy),     64'd0);
    chk("rst_full",     64'(bus.full),     64'd0);
    chk_en = 1'b1;

    // Basic frame 3,5,7
    cyc_in(1'b1, 32'd3, 1'b0); cyc_in(1'b1, 32'd5, 1'b0); cyc_in(1'b1, 32'd7, 1'b0);
    cyc_in(1'b0, 32'd0, 1'b1);
    wait_idle();
    chk("basic_sum", sum_at(0), 64'd15);
    chk("basic_w0", word_at(0), 64'd3);
    chk("basic_w1", word_at(1), 64'd5);
    chk("basic_w2", word_at(2), 64'd7);
    chk("basic_count", 64'(bus.count), 64'd0);

    // Single word
    cyc_in(1'b1, 32'hFFFF_FFFF, 1'b0); cyc_in(1'b0, 32'd0, 1'b1);
    wait_idle();
    chk("single_sum", sum_at(1), 64'h0_FFFF_FFFF);

    // Full / overflow
    ovf_base = ovf_cnt;
    for (int i = 1; i <= 17; i++) cyc_in(1'b1, NB'(i), 1'b0);
    cyc_in(1'b0, 32'd0, 1'b0);
    chk("full_count", 64'(bus.count), 64'd16);
    chk("full_flag",  64'(bus.full),  64'd1);
    chk("ovf_once",   64'(ovf_cnt - ovf_base), 64'd1);
    cyc_in(1'b0, 32'd0, 1'b1);
    wait_idle();
    chk("full_sum", sum_at(2), 64'd136);

    // Start together with a write
    cyc_in(1'b1, 32'd5, 1'b0); cyc_in(1'b1, 32'd6, 1'b0); cyc_in(1'b1, 32'd9, 1'b1);
    wait_idle();
    chk("simul_sum", sum_at(3), 64'd20);
    chk("simul_last", word_at(words.size() - 1), 64'd9);

    // Start with empty buffer
    cyc_in(1'b0, 32'd0, 1'b1); cyc_in(1'b0, 32'd0, 1'b0);
    chk("empty_busy", 64'(bus.busy), 64'd0);
    chk("empty_frames", 64'(sums.size()), 64'd4);

    // Writes during SEND / WAIT_DONE are ignored
    cyc_in(1'b1, 32'd1, 1'b0); cyc_in(1'b1, 32'd2, 1'b0); cyc_in(1'b1, 32'd3, 1'b1);
    for (int n = 0; n < 300 && e_busy; n++) cyc_in(1'b1, NB'($urandom), 1'b0);
    chk("ign_count", 64'(bus.count), 64'd0);
    chk("ign_sum", sum_at(4), 64'd6);

    // Back-to-back with earliest legal restart
    cyc_in(1'b1, 32'd1, 1'b0); cyc_in(1'b1, 32'd2, 1'b0); cyc_in(1'b0, 32'd0, 1'b1);
    for (int n = 0; n < 300 && !e_sent; n++) @(negedge clk);
    chk("b2b_sent_seen", 64'(e_sent), 64'd1);
    cyc_in(1'b1, 32'd4, 1'b1);
    wait_idle();
    chk("b2b_sum0", sum_at(5), 64'd3);
    chk("b2b_sum1", sum_at(6), 64'd4);

    // Randomized traffic with arbitrary sum_done timing
    auto_done = 1'b0; rnd_done = 1'b1;
    repeat (1500) cyc_in(1'($urandom_range(0, 1)), NB'($urandom), ($urandom_range(0, 6) == 0));
    wait_idle();
    rnd_done = 1'b0; auto_done = 1'b1;
    cyc_in(1'b0, 32'd0, 1'b0);

    // Reset mid-SEND: outputs drop asynchronously
    if (bus.count != '0) begin
      cyc_in(1'b0, 32'd0, 1'b1);
      wait_idle();
    end
    cyc_in(1'b1, 32'd8, 1'b0); cyc_in(1'b1, 32'd9, 1'b0); cyc_in(1'b0, 32'd0, 1'b1);
    chk("pre_rst_first", 64'(bus.data_first), 64'd1);
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_data_out", 64'(bus.data_out),   64'd0);
    chk("arst_first",    64'(bus.data_first), 64'd0);
    chk("arst_last",     64'(bus.data_last),  64'd0);
    chk("arst_busy",     64'(bus.busy),       64'd0);
    chk("arst_count",    64'(bus.count),      64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_count", 64'(bus.count), 64'd0);
    chk("post_rst_busy",  64'(bus.busy),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
